// File: rtl/regfile_ctx_engine_pkg.sv
// Shared constants for the register-file context save/restore engine.
package regfile_ctx_engine_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_FIRST = 5'd1;
  localparam logic [ADDR_W-1:0] REG_LAST  = 5'd31;
  localparam logic [ADDR_W-1:0] SP_IDX    = 5'd29;
  localparam logic [DATA_W-1:0] SP_RESET  = 32'h0000_07fc;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_RESTORE = 3'd2;
  localparam logic [2:0] ST_CSUM_TX = 3'd3;
  localparam logic [2:0] ST_CSUM_RX = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Saturates at REG_LAST so the index never wraps onto r0.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
    return (idx == REG_LAST) ? REG_LAST : idx + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/regctx_xor_acc.sv
// XOR fold accumulator for the context-stream checksum.
// Present only when REGCTX_CHECKSUM_EN is defined.
`ifdef REGCTX_CHECKSUM_EN
module regctx_xor_acc
  import regfile_ctx_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        acc_q <= '0;
    else if (clear_i) acc_q <= '0;
    else if (en_i)    acc_q <= acc_q ^ din_i;
  end

  assign acc_o = acc_q;

endmodule
`endif

// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine: streams r1..r31 out of / back into the register file.
// Define REGCTX_CHECKSUM_EN to append and verify an XOR checksum word.
module regfile_ctx_engine
  import regfile_ctx_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_hs, in_hs, in_ready_c;

`ifdef REGCTX_CHECKSUM_EN
  logic              acc_clear, acc_en;
  logic [DATA_W-1:0] acc_din, acc;
  logic              err_q, err_d;

  regctx_xor_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear_i(acc_clear),
    .en_i   (acc_en),
    .din_i  (acc_din),
    .acc_o  (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready_c = (state_q == ST_RESTORE) || (state_q == ST_CSUM_RX);
  assign out_hs     = out_valid_q && out_ready;
  assign in_hs      = in_valid && in_ready_c;

  // Read port runs one word ahead so the next beat loads on the handshake edge.
  assign rf_read_addr  = (state_q == ST_SAVE) ? next_idx(idx_q) :
                         ((state_q == ST_IDLE) && save_req) ? REG_FIRST : '0;
  assign rf_reg_write  = in_hs && (state_q == ST_RESTORE);
  assign rf_write_addr = rf_reg_write ? idx_q : '0;
  assign rf_write_data = rf_reg_write ? in_data : '0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef REGCTX_CHECKSUM_EN
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    acc_din     = out_data_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (save_req || restore_req) begin
          idx_d = REG_FIRST;
`ifdef REGCTX_CHECKSUM_EN
          acc_clear = 1'b1;
          err_d     = 1'b0;
`endif
          if (save_req) begin
            state_d     = ST_SAVE;
            out_valid_d = 1'b1;
            out_data_d  = rf_read_data;
          end else begin
            state_d = ST_RESTORE;
          end
        end
      end
      ST_SAVE: begin
        if (out_hs) begin
`ifdef REGCTX_CHECKSUM_EN
          acc_en  = 1'b1;
          acc_din = out_data_q;
`endif
          if (idx_q == REG_LAST) begin
`ifdef REGCTX_CHECKSUM_EN
            state_d    = ST_CSUM_TX;
            out_data_d = acc ^ out_data_q;
`else
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
`endif
          end else begin
            idx_d      = next_idx(idx_q);
            out_data_d = rf_read_data;
          end
        end
      end
      ST_RESTORE: begin
        if (in_hs) begin
`ifdef REGCTX_CHECKSUM_EN
          acc_en  = 1'b1;
          acc_din = in_data;
`endif
          if (idx_q == REG_LAST) begin
`ifdef REGCTX_CHECKSUM_EN
            state_d = ST_CSUM_RX;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = next_idx(idx_q);
          end
        end
      end
`ifdef REGCTX_CHECKSUM_EN
      ST_CSUM_TX: begin
        if (out_hs) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b0;
        end
      end
      ST_CSUM_RX: begin
        if (in_hs) begin
          state_d = ST_DONE;
          if (in_data != acc) err_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = REG_FIRST;
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = REG_FIRST;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= REG_FIRST;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_c;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Bench for regfile_ctx_engine paired with a behavioural register-file model.
// Define REGCTX_CHECKSUM_EN to exercise the checksum build.
module tb_regfile_ctx_engine;
  import regfile_ctx_engine_pkg::*;

`ifdef REGCTX_CHECKSUM_EN
  localparam int NW = 32;
`else
  localparam int NW = 31;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              save_req, restore_req;
  logic              busy, done, err;
  logic [ADDR_W-1:0] rf_read_addr, rf_write_addr;
  logic [DATA_W-1:0] rf_read_data, rf_write_data;
  logic              rf_reg_write;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] rf      [NUM_REGS];
  logic [DATA_W-1:0] rf_init [NUM_REGS];
  logic              rf_load = 1'b0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] w [NUM_REGS];

  regfile_ctx_engine dut (
    .clk          (clk),
    .reset        (reset),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_reg_write (rf_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data)
  );

  always #5 clk = ~clk;

  // Register file model: r0 reads as zero, any write lands in the array so stray r0 writes are visible.
  assign rf_read_data = (rf_read_addr == '0) ? '0 : rf[rf_read_addr];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= rf_init[i];
    end else if (rf_reg_write) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf();
    rf_load = 1'b1;
    tick();
    rf_load = 1'b0;
  endtask

  task automatic randomize_rf();
    rf_init[0] = '0;
    for (int k = 1; k < NUM_REGS; k++) rf_init[k] = $urandom;
    load_rf();
  endtask

  // Expected save stream: r1..r31 in order, then their XOR when the checksum is built in.
  task automatic fill_save_exp();
    logic [DATA_W-1:0] c;
    c = '0;
    exp_q.delete();
    for (int k = 1; k < NUM_REGS; k++) begin
      exp_q.push_back(rf_init[k]);
      c = c ^ rf_init[k];
    end
    if (NW == 32) exp_q.push_back(c);
  endtask

  task automatic test_reset();
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < NUM_REGS; k++) rf_init[k] = '0;
    rf_init[SP_IDX] = SP_RESET;
    rf_load = 1'b1;
    repeat (2) tick();
    rf_load = 1'b0;
    n_cmp++;
    if ({busy, done, err, out_valid, in_ready, rf_reg_write} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, err, out_valid, in_ready, rf_reg_write});
    end
    n_cmp++;
    if (rf_read_addr !== '0 || rf_write_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addrs: got rd=%0d wr=%0d expected 0/0", rf_read_addr, rf_write_addr);
    end
    n_cmp++;
    if (rf_write_data !== '0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got wd=%h od=%h expected 0/0", rf_write_data, out_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_save_consecutive();
    rf_init[0] = '0;
    for (int k = 1; k < NUM_REGS; k++) rf_init[k] = 32'(k) * 32'h0101_0101;
    load_rf();
    fill_save_exp();
    out_ready = 1'b1;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL save_busy_rise: got %b expected 1", busy);
    end
    for (int k = 0; k < NW; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin
        n_err++;
        $display("FAIL save_beat%0d: got v=%b d=%h expected v=1 d=%h", k + 1, out_valid, out_data, exp_q[k]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL save_done: got done=%b busy=%b v=%b expected 1/1/0", done, busy, out_valid);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL save_idle: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_save_stall();
    int n;
    bit seen_done, prev_stall;
    logic [DATA_W-1:0] prev_data;
    n = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    randomize_rf();
    fill_save_exp();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      out_ready = (cyc % 2 == 1);
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_valid_drop: got %b expected 1 at cycle %0d", out_valid, cyc);
        end
        if (prev_stall) begin
          n_cmp++;
          if (out_data !== prev_data) begin
            n_err++;
            $display("FAIL stall_hold: got %h expected %h", out_data, prev_data);
          end
        end
        if (out_ready) begin
          n_cmp++;
          if (n >= NW) begin
            n_err++;
            $display("FAIL stall_extra_beat: got beat %0d expected at most %0d", n + 1, NW);
          end else if (out_data !== exp_q[n]) begin
            n_err++;
            $display("FAIL stall_beat%0d: got %h expected %h", n + 1, out_data, exp_q[n]);
          end
          n++;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        tick();
      end
    end
    n_cmp++;
    if (!seen_done || n != NW) begin
      n_err++;
      $display("FAIL stall_count: got beats=%0d done=%b expected %0d/1", n, seen_done, NW);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_restore_gaps();
    logic [DATA_W-1:0] c;
    c = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      w[k] = 32'hA000_0000 + 32'(k);
      c = c ^ w[k];
    end
    randomize_rf();
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL restore_start: got busy=%b in_ready=%b expected 1/1", busy, in_ready);
    end
    for (int k = 1; k <= NW; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = (k < NUM_REGS) ? w[k] : c;
      #1;
      n_cmp++;
      if (k < NUM_REGS) begin
        if (rf_reg_write !== 1'b1 || rf_write_addr !== ADDR_W'(k) || rf_write_data !== w[k]) begin
          n_err++;
          $display("FAIL restore_wr%0d: got we=%b a=%0d d=%h expected 1/%0d/%h",
                   k, rf_reg_write, rf_write_addr, rf_write_data, k, w[k]);
        end
      end else if (rf_reg_write !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL restore_csum_beat: got we=%b rdy=%b expected 0/1", rf_reg_write, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL restore_done: got done=%b err=%b expected 1/0", done, err);
    end
    tick();
    for (int k = 1; k < NUM_REGS; k++) begin
      n_cmp++;
      if (rf[k] !== w[k]) begin
        n_err++;
        $display("FAIL restore_r%0d: got %h expected %h", k, rf[k], w[k]);
      end
    end
    n_cmp++;
    if (rf[0] !== '0) begin
      n_err++;
      $display("FAIL restore_r0: got %h expected 0", rf[0]);
    end
    n_cmp++;
    if (rf[SP_IDX] !== 32'hA000_001D) begin
      n_err++;
      $display("FAIL restore_sp: got %h expected a000001d", rf[SP_IDX]);
    end
  endtask

  task automatic test_simultaneous();
    bit changed;
    randomize_rf();
    fill_save_exp();
    out_ready = 1'b1;
    save_req = 1'b1;
    restore_req = 1'b1;
    tick();
    save_req = 1'b0;
    for (int k = 0; k < NW; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_q[k]) begin
        n_err++;
        $display("FAIL simul_beat%0d: got v=%b rdy=%b d=%h expected 1/0/%h",
                 k + 1, out_valid, in_ready, out_data, exp_q[k]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL simul_done: got %b expected 1", done);
    end
    restore_req = 1'b0;
    tick();
    changed = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) if (rf[k] !== rf_init[k]) changed = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || changed) begin
      n_err++;
      $display("FAIL simul_ignored: got busy=%b rdy=%b rf_changed=%b expected 0/0/0", busy, in_ready, changed);
    end
  endtask

  task automatic test_reset_abort();
    randomize_rf();
    for (int k = 1; k < NUM_REGS; k++) w[k] = $urandom;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = w[k];
      tick();
    end
    in_data = w[11];
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, err, out_valid, in_ready, rf_reg_write} !== 6'b0) begin
      n_err++;
      $display("FAIL abort_outputs: got %b expected 000000", {busy, done, err, out_valid, in_ready, rf_reg_write});
    end
    n_cmp++;
    if (rf_write_addr !== '0 || rf_write_data !== '0 || out_data !== '0) begin
      n_err++;
      $display("FAIL abort_buses: got wa=%0d wd=%h od=%h expected 0", rf_write_addr, rf_write_data, out_data);
    end
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 1; k < NUM_REGS; k++) begin
      n_cmp++;
      if (rf[k] !== ((k <= 10) ? w[k] : rf_init[k])) begin
        n_err++;
        $display("FAIL abort_r%0d: got %h expected %h", k, rf[k], (k <= 10) ? w[k] : rf_init[k]);
      end
    end
  endtask

`ifdef REGCTX_CHECKSUM_EN
  task automatic test_checksum_err();
    logic [DATA_W-1:0] c;
    bit seen_done;
    c = '0;
    seen_done = 1'b0;
    randomize_rf();
    for (int k = 1; k < NUM_REGS; k++) begin
      w[k] = $urandom;
      c = c ^ w[k];
    end
    c = c ^ (32'h1 << $urandom_range(0, 31));
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= NW; k++) begin
      in_data = (k < NUM_REGS) ? w[k] : c;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_err++;
      $display("FAIL csum_err_set: got done=%b err=%b expected 1/1", done, err);
    end
    tick();
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL csum_err_sticky: got err=%b busy=%b expected 1/0", err, busy);
    end
    out_ready = 1'b1;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL csum_err_clear: got %b expected 0", err);
    end
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      if (done === 1'b1) seen_done = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen_done) begin
      n_err++;
      $display("FAIL csum_save_timeout: got done=0 expected 1 within 100 cycles");
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_save_consecutive();
    test_save_stall();
    test_restore_gaps();
    test_simultaneous();
    test_reset_abort();
`ifdef REGCTX_CHECKSUM_EN
    test_checksum_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
